// File: rtl/music_pkg.sv
// Shared types and constants for the music-box melody path: table entry layout,
// note codes (C4..B6 chromatic), sequencer states and the note divisor helper.
package music_pkg;

  localparam int CODE_W  = 6;
  localparam int DUR_W   = 4;
  localparam int ENTRY_W = CODE_W + DUR_W;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [DUR_W-1:0]  dur_t;

  typedef struct packed {
    code_t code;
    dur_t  dur;
  } entry_t;

  localparam entry_t END_MARKER = '{code: '0, dur: '0};

  localparam code_t REST = 6'd0;
  localparam code_t C4 = 6'd1,  CS4 = 6'd2,  D4 = 6'd3,  DS4 = 6'd4,  E4 = 6'd5,  F4 = 6'd6;
  localparam code_t FS4 = 6'd7, G4 = 6'd8,   GS4 = 6'd9, A4 = 6'd10,  AS4 = 6'd11, B4 = 6'd12;
  localparam code_t C5 = 6'd13, CS5 = 6'd14, D5 = 6'd15, DS5 = 6'd16, E5 = 6'd17, F5 = 6'd18;
  localparam code_t FS5 = 6'd19, G5 = 6'd20, GS5 = 6'd21, A5 = 6'd22, AS5 = 6'd23, B5 = 6'd24;
  localparam code_t C6 = 6'd25, CS6 = 6'd26, D6 = 6'd27, DS6 = 6'd28, E6 = 6'd29, F6 = 6'd30;
  localparam code_t FS6 = 6'd31, G6 = 6'd32, GS6 = 6'd33, A6 = 6'd34, AS6 = 6'd35, B6 = 6'd36;

  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_PLAY, ST_GAP, ST_END} state_t;

  // Equal-tempered frequencies in milli-hertz, A4 = 440 Hz.
  function automatic longint note_freq_mhz(int code);
    case (code)
      1:  return 261626;  2:  return 277183;  3:  return 293665;  4:  return 311127;
      5:  return 329628;  6:  return 349228;  7:  return 369994;  8:  return 391995;
      9:  return 415305;  10: return 440000;  11: return 466164;  12: return 493883;
      13: return 523251;  14: return 554365;  15: return 587330;  16: return 622254;
      17: return 659255;  18: return 698456;  19: return 739989;  20: return 783991;
      21: return 830609;  22: return 880000;  23: return 932328;  24: return 987767;
      25: return 1046502; 26: return 1108731; 27: return 1174659; 28: return 1244508;
      29: return 1318510; 30: return 1396913; 31: return 1479978; 32: return 1567982;
      33: return 1661219; 34: return 1760000; 35: return 1864655; 36: return 1975533;
      default: return 0;
    endcase
  endfunction

  // Rounded half period in clocks, CLK_HZ / (2 * f); 0 for rests and unused codes.
  function automatic longint half_period(longint clk_hz, int code);
    longint f;
    f = note_freq_mhz(code);
    if (f == 0) return 0;
    return (clk_hz * 1000 + f) / (2 * f);
  endfunction

endpackage

// File: rtl/note_div_rom.sv
// Combinational note code to half-period divisor lookup; every entry is folded
// to a constant at elaboration from CLK_HZ.
module note_div_rom
  import music_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int DIV_W  = 16
) (
  input  logic [CODE_W-1:0] note_code,
  output logic [DIV_W-1:0]  note_div
);

  logic [DIV_W-1:0] rom [2**CODE_W];

  for (genvar g = 0; g < 2**CODE_W; g++) begin : g_rom
    localparam logic [DIV_W-1:0] DIV = DIV_W'(half_period(longint'(CLK_HZ), g));
    assign rom[g] = DIV;
  end

  assign note_div = rom[note_code];

endmodule

// File: rtl/melody_sequencer.sv
// Music-box melody sequencer: walks a fixed note table and presents the tone
// generator with a half-period divisor, a gate and a per-note strobe.
module melody_sequencer
  import music_pkg::*;
#(
  parameter int CLK_HZ    = 12_000_000,
  parameter int TICK_CLKS = 1_500_000,
  parameter int GAP_CLKS  = 120_000,
  parameter int SONG_LEN  = 32,
  parameter int DIV_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  output logic [DIV_W-1:0] note_div,
  output logic             note_gate,
  output logic             note_strobe,
  output logic             busy,
  output logic             song_done
);

  localparam int IDX_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam int CNT_W = $clog2(15 * TICK_CLKS + 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CLKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

  if (GAP_CLKS >= TICK_CLKS) begin : g_bad_gap
    $error("melody_sequencer: GAP_CLKS must be smaller than TICK_CLKS");
  end

  state_t           state, state_next;
  logic [IDX_W-1:0] index;
  logic             wrap_pending;
  logic [CNT_W-1:0] cnt;
  entry_t           entry;
  logic [DIV_W-1:0] rom_div;
  logic             is_end;
  logic             note_done;

  always_comb begin
    entry = END_MARKER;
    case (index)
      IDX_W'(0): entry = '{code: A4,   dur: 4'd2};
      IDX_W'(1): entry = '{code: REST, dur: 4'd1};
      IDX_W'(2): entry = '{code: C5,   dur: 4'd1};
      default:   entry = END_MARKER;
    endcase
  end

  note_div_rom #(
    .CLK_HZ(CLK_HZ),
    .DIV_W (DIV_W)
  ) u_rom (
    .note_code(entry.code),
    .note_div (rom_div)
  );

  // Running off the last table slot behaves exactly like reading an end marker.
  assign is_end = wrap_pending || (entry.dur == '0);

  always_comb begin
    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_FETCH;
      ST_FETCH: state_next = is_end ? ST_END : ST_PLAY;
      ST_PLAY:  if (cnt == GAP_END) state_next = (GAP_CLKS == 0) ? ST_FETCH : ST_GAP;
      ST_GAP:   if (cnt == CNT_W'(1)) state_next = ST_FETCH;
      ST_END:   state_next = loop_en ? ST_FETCH : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (stop) state_next = ST_IDLE;
  end

  assign note_done = ((state == ST_PLAY) || (state == ST_GAP)) && (state_next == ST_FETCH);
  assign busy      = (state != ST_IDLE);
  assign song_done = (state == ST_END) && !loop_en && !stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      index        <= '0;
      wrap_pending <= 1'b0;
      cnt          <= '0;
      note_div     <= '0;
      note_gate    <= 1'b0;
      note_strobe  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_next;
      note_strobe <= 1'b0;
      if (stop) begin
        index        <= '0;
        wrap_pending <= 1'b0;
        cnt          <= '0;
        note_div     <= '0;
        note_gate    <= 1'b0;
      end else begin
        case (state)
          ST_FETCH: begin
            if (!is_end) begin
              // cnt holds the clocks remaining in this note, FETCH excluded.
              cnt         <= CNT_W'(entry.dur) * CNT_W'(TICK_CLKS);
              note_div    <= rom_div;
              note_gate   <= (entry.code != REST);
              note_strobe <= 1'b1;
            end
          end
          ST_PLAY: begin
            cnt <= cnt - 1'b1;
            if (cnt == GAP_END) note_gate <= 1'b0;
          end
          ST_GAP: cnt <= cnt - 1'b1;
          ST_END: begin
            index        <= '0;
            wrap_pending <= 1'b0;
            if (!loop_en) begin
              note_div  <= '0;
              note_gate <= 1'b0;
            end
          end
          default: ;
        endcase
        if (note_done) begin
          if (index == LAST_IDX) begin
            index        <= '0;
            wrap_pending <= 1'b1;
          end else begin
            index <= index + 1'b1;
          end
        end
      end
    end
  end

endmodule
